ahb_uart_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 37 +++
 rtl/loader_uart_rx.sv | 121 ++++++++++++
 rtl/ahb_uart_loader.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_ahb_uart_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared constants and state types for the UART boot loader.
// LOADER_CHECKSUM_EN adds the CSUM frame state.
package loader_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'hA5;
  localparam logic [7:0] CMD_RELEASE = 8'h5A;
  localparam logic [7:0] CMD_HOLD    = 8'hC3;
  localparam logic [7:0] CMD_CLRERR  = 8'hE1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ST_CSUM  = 3'd3,
`endif
    ST_AHB_A = 3'd4,
    ST_AHB_D = 3'd5
  } frame_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Running frame checksum: XOR of every address/data byte.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, byte strobe
// and framing-error pulse. Both outputs are single-cycle and registered.
module loader_uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       strobe_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            strobe_q, strobe_d;
  logic            ferr_q, ferr_d;

  // Bit timing: wait half a bit to confirm start, then one full bit per sample.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          bit_d = 3'd0;
          if (!sync2_q) begin
            state_d = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = RX_IDLE;
          if (sync2_q) begin
            strobe_d = 1'b1;
            byte_d   = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      state_q  <= RX_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      byte_q   <= 8'h00;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync1_q  <= rx_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
    end
  end

  assign byte_o      = byte_q;
  assign strobe_o    = strobe_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/ahb_uart_loader.sv
// UART boot loader acting as an AHB-Lite write master while holding the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module ahb_uart_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 500000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        rx_i,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] wr_count_o
);

  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  logic [7:0]   rx_byte_s;
  logic         rx_strobe_s, rx_ferr_s;
  logic         buf_valid_q, buf_valid_d;
  logic [7:0]   buf_data_q, buf_data_d;
  logic         consume_s, ovr_s, in_frame_s, timeout_s;
  logic         fsm_err_s, err_clr_s;
  frame_state_e state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [31:0]  addr_q, addr_d, data_q, data_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]   csum_q, csum_d;
`endif
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [31:0]  haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic [1:0]   htrans_q, htrans_d;
  logic         hwrite_q, hwrite_d, cpu_rst_q, cpu_rst_d;
  logic         err_q, err_d, busy_q, busy_d;
  logic [15:0]  wr_cnt_q, wr_cnt_d;

  loader_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i       (HCLK),
    .rst_i       (HRESET),
    .rx_i        (rx_i),
    .byte_o      (rx_byte_s),
    .strobe_o    (rx_strobe_s),
    .frame_err_o (rx_ferr_s)
  );

  // The buffer is drained in every state except the two AHB phases.
  assign consume_s = buf_valid_q && (state_q != ST_AHB_A) && (state_q != ST_AHB_D);

  // One-entry byte buffer; a strobe that finds it full and not draining is an overrun.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    ovr_s       = 1'b0;
    if (rx_strobe_s) begin
      if (buf_valid_q && !consume_s) begin
        ovr_s = 1'b1;
      end else begin
        buf_valid_d = 1'b1;
        buf_data_d  = rx_byte_s;
      end
    end else if (consume_s) begin
      buf_valid_d = 1'b0;
    end else begin
      buf_valid_d = buf_valid_q;
    end
  end

  // Inter-byte timeout runs only while a frame is being collected.
  always_comb begin
    in_frame_s = (state_q == ST_ADDR) || (state_q == ST_DATA);
`ifdef LOADER_CHECKSUM_EN
    in_frame_s = in_frame_s || (state_q == ST_CSUM);
`endif
    if (!in_frame_s || rx_strobe_s) begin
      to_cnt_d = {TO_W{1'b0}};
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    timeout_s = in_frame_s && (to_cnt_q == TO_LAST);
  end

  // Frame FSM: command decode, little-endian word assembly, AHB address/data phases.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cpu_rst_d = cpu_rst_q;
    wr_cnt_d  = wr_cnt_q;
    fsm_err_s = 1'b0;
    err_clr_s = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (consume_s) begin
          case (buf_data_q)
            CMD_WRITE: begin
              state_d = ST_ADDR;
              idx_d   = 2'd0;
`ifdef LOADER_CHECKSUM_EN
              csum_d  = 8'h00;
`endif
            end
            CMD_RELEASE: cpu_rst_d = 1'b0;
            CMD_HOLD:    cpu_rst_d = 1'b1;
            CMD_CLRERR:  err_clr_s = 1'b1;
            default:     state_d   = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (consume_s) begin
          addr_d[{idx_q, 3'b000} +: 8] = buf_data_q;
          idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_update(csum_q, buf_data_q);
`endif
          if (idx_q == 2'd3) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_ADDR;
          end
        end else if (timeout_s) begin
          state_d   = ST_IDLE;
          fsm_err_s = 1'b1;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (consume_s) begin
          data_d[{idx_q, 3'b000} +: 8] = buf_data_q;
          idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_update(csum_q, buf_data_q);
          if (idx_q == 2'd3) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
`else
          if (idx_q != 2'd3) begin
            state_d = ST_DATA;
          end else if (cpu_rst_q) begin
            state_d = ST_AHB_A;
          end else begin
            state_d   = ST_IDLE;
            fsm_err_s = 1'b1;
          end
`endif
        end else if (timeout_s) begin
          state_d   = ST_IDLE;
          fsm_err_s = 1'b1;
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (consume_s) begin
          if ((buf_data_q == csum_q) && cpu_rst_q) begin
            state_d = ST_AHB_A;
          end else begin
            state_d   = ST_IDLE;
            fsm_err_s = 1'b1;
          end
        end else if (timeout_s) begin
          state_d   = ST_IDLE;
          fsm_err_s = 1'b1;
        end else begin
          state_d = ST_CSUM;
        end
      end
`endif
      ST_AHB_A: begin
        if (HREADY) begin
          state_d = ST_AHB_D;
        end else begin
          state_d = ST_AHB_A;
        end
      end
      ST_AHB_D: begin
        if (HREADY) begin
          state_d  = ST_IDLE;
          wr_cnt_d = wr_cnt_q + 16'd1;
        end else begin
          state_d = ST_AHB_D;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state; address/data latch on phase entry.
  always_comb begin
    htrans_d = (state_d == ST_AHB_A) ? HTRANS_NONSEQ : HTRANS_IDLE;
    hwrite_d = (state_d == ST_AHB_A);
    busy_d   = (state_d != ST_IDLE);
    if ((state_d == ST_AHB_A) && (state_q != ST_AHB_A)) begin
      haddr_d = addr_q & 32'hFFFF_FFFC;
    end else begin
      haddr_d = haddr_q;
    end
    if ((state_d == ST_AHB_D) && (state_q == ST_AHB_A)) begin
      hwdata_d = data_q;
    end else begin
      hwdata_d = hwdata_q;
    end
    if (ovr_s || rx_ferr_s || fsm_err_s) begin
      err_d = 1'b1;
    end else if (err_clr_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= 8'h00;
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      addr_q      <= 32'h0000_0000;
      data_q      <= 32'h0000_0000;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
      to_cnt_q    <= {TO_W{1'b0}};
      haddr_q     <= 32'h0000_0000;
      hwdata_q    <= 32'h0000_0000;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      cpu_rst_q   <= 1'b1;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      wr_cnt_q    <= 16'h0000;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
      to_cnt_q    <= to_cnt_d;
      haddr_q     <= haddr_d;
      hwdata_q    <= hwdata_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      cpu_rst_q   <= cpu_rst_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign HADDR      = haddr_q;
  assign HTRANS     = htrans_q;
  assign HWRITE     = hwrite_q;
  assign HSIZE      = HSIZE_WORD;
  assign HWDATA     = hwdata_q;
  assign cpu_rst_o  = cpu_rst_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;
  assign wr_count_o = wr_cnt_q;

endmodule

// File: tb/tb_ahb_uart_loader.sv
// Directed bench for ahb_uart_loader with shortened bit and timeout periods.
module tb_ahb_uart_loader;

  localparam int CPB = 8;
  localparam int TO  = 300;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        rx = 1'b1;
  logic        HREADY = 1'b1;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, cpu_rst, busy, err;
  logic [2:0]  HSIZE;
  logic [15:0] wr_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_addr = 0;
  int n_wr = 0;
  int done_cyc = 0;
  logic        dphase = 1'b0;
  logic [31:0] cap_addr = 32'h0;
  logic [31:0] cap_data = 32'h0;
  int t0, lat0, lat1;

  ahb_uart_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .rx_i       (rx),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .cpu_rst_o  (cpu_rst),
    .busy_o     (busy),
    .err_o      (err),
    .wr_count_o (wr_count)
  );

  always #5 HCLK = ~HCLK;

  // Bus monitor: counts accepted address phases and completed data phases.
  always @(posedge HCLK) begin
    cyc <= cyc + 1;
    if (HRESET) begin
      dphase <= 1'b0;
    end else begin
      if (dphase && HREADY) begin
        cap_data <= HWDATA;
        n_wr     <= n_wr + 1;
        done_cyc <= cyc;
        dphase   <= 1'b0;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        cap_addr <= HADDR;
        n_addr   <= n_addr + 1;
        dphase   <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge HCLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge HCLK);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge HCLK);
    rx = 1'b1;
    if (!stop_bit) repeat (2 * CPB) @(negedge HCLK);
  endtask

  task automatic send_payload(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
  endtask

`ifdef LOADER_CHECKSUM_EN
  function automatic logic [7:0] xor8(input logic [31:0] a, input logic [31:0] d);
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i < 4; i++) cs = cs ^ a[8*i +: 8] ^ d[8*i +: 8];
    return cs;
  endfunction
`endif

  task automatic send_frame(input logic [31:0] a, input logic [31:0] d);
    send_payload(a, d);
`ifdef LOADER_CHECKSUM_EN
    send_byte(xor8(a, d), 1'b1);
`endif
  endtask

  task automatic wait_wr(input int n);
    for (int k = 0; k < 500 && n_wr < n; k++) @(negedge HCLK);
    check("write_done", n_wr, n);
  endtask

  // Holds HREADY low for three edges in both the address and data phase.
  task automatic stall_write(input logic [31:0] exp_addr, input logic [31:0] exp_data);
    for (int k = 0; k < 3000 && HTRANS != 2'b10; k++) @(negedge HCLK);
    check("stall_nonseq_seen", HTRANS, 2'b10);
    HREADY = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      check("hold_htrans", HTRANS, 2'b10);
      check("hold_haddr", HADDR, exp_addr);
    end
    HREADY = 1'b1;
    @(negedge HCLK);
    HREADY = 1'b0;
    check("dphase_htrans", HTRANS, 2'b00);
    check("dphase_hwrite", HWRITE, 1'b0);
    repeat (3) begin
      @(negedge HCLK);
      check("hold_hwdata", HWDATA, exp_data);
      check("hold_haddr_d", HADDR, exp_addr);
    end
    HREADY = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge HCLK);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_hwrite", HWRITE, 1'b0);
    check("rst_hsize", HSIZE, 3'b010);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_wr_count", wr_count, 16'h0);
    HRESET = 1'b0;
    repeat (4) @(negedge HCLK);

    // Zero-wait write
    t0 = cyc;
    send_frame(32'h1000_0000, 32'hDEAD_BEEF);
    wait_wr(1);
    lat0 = done_cyc - t0;
    check("w1_nonseq_count", n_addr, 1);
    check("w1_addr", cap_addr, 32'h1000_0000);
    check("w1_data", cap_data, 32'hDEAD_BEEF);
    check("w1_wr_count", wr_count, 16'd1);
    check("w1_err", err, 1'b0);
    check("w1_busy", busy, 1'b0);
    repeat (4) @(negedge HCLK);

    // Same frame with three wait states per phase
    t0 = cyc;
    fork
      send_frame(32'h1000_0000, 32'hDEAD_BEEF);
      stall_write(32'h1000_0000, 32'hDEAD_BEEF);
    join
    wait_wr(2);
    lat1 = done_cyc - t0;
    check("w2_nonseq_count", n_addr, 2);
    check("w2_data", cap_data, 32'hDEAD_BEEF);
    check("w2_wr_count", wr_count, 16'd2);
    check("w2_extra_latency", lat1 - lat0, 6);
    repeat (4) @(negedge HCLK);

    // Partial frame then silence
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (4) @(negedge HCLK);
    check("to_busy_before", busy, 1'b1);
    repeat (TO + 50) @(negedge HCLK);
    check("to_busy_after", busy, 1'b0);
    check("to_err", err, 1'b1);
    check("to_no_transfer", n_addr, 2);
    send_byte(8'hE1, 1'b1);
    repeat (4) @(negedge HCLK);
    check("clrerr", err, 1'b0);

    // Released CPU: frame parsed but not issued
    send_byte(8'h5A, 1'b1);
    repeat (4) @(negedge HCLK);
    check("release_cpu", cpu_rst, 1'b0);
    send_frame(32'h1000_0040, 32'h0BAD_F00D);
    repeat (20) @(negedge HCLK);
    check("rel_no_transfer", n_addr, 2);
    check("rel_err", err, 1'b1);
    check("rel_busy", busy, 1'b0);
    send_byte(8'hC3, 1'b1);
    repeat (4) @(negedge HCLK);
    check("hold_cpu", cpu_rst, 1'b1);
    send_byte(8'hE1, 1'b1);
    repeat (4) @(negedge HCLK);
    check("clrerr2", err, 1'b0);

    // Framing error on a command byte: dropped, no frame started
    send_byte(8'hA5, 1'b0);
    repeat (4) @(negedge HCLK);
    check("ferr_err", err, 1'b1);
    check("ferr_dropped", busy, 1'b0);
    send_byte(8'hE1, 1'b1);
    repeat (4) @(negedge HCLK);
    check("clrerr3", err, 1'b0);

    // Unaligned address is forced to word alignment
    send_frame(32'h2000_0013, 32'h1234_5678);
    wait_wr(3);
    check("align_addr", cap_addr, 32'h2000_0010);
    check("align_haddr_low", HADDR[1:0], 2'b00);
    check("align_data", cap_data, 32'h1234_5678);
    check("align_wr_count", wr_count, 16'd3);
    check("align_err", err, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum byte: no write, error raised
    send_payload(32'h3000_0000, 32'hCAFE_0001);
    send_byte(xor8(32'h3000_0000, 32'hCAFE_0001) ^ 8'h01, 1'b1);
    repeat (20) @(negedge HCLK);
    check("csum_bad_no_write", n_addr, 3);
    check("csum_bad_err", err, 1'b1);
    check("csum_bad_count", wr_count, 16'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
